// File: rtl/branch_predict_unit.sv
// Bimodal branch predictor: a tagless table of 2-bit counters and targets looked up at fetch,
// with branch resolution, redirect generation and statistics at execute.
module branch_predict_unit #(
    parameter int XLEN      = 64,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] f_pc,
    output logic            f_pred_taken,
    output logic [XLEN-1:0] f_pred_target,
    input  logic            ex_valid,
    input  logic [2:0]      ex_format,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_a,
    input  logic [XLEN-1:0] ex_b,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            res_taken,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);

    localparam int IDX = $clog2(BHT_DEPTH);
    localparam logic [2:0] FMT_B = 3'b011;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic            valid_q [BHT_DEPTH];
    logic            valid_d [BHT_DEPTH];
    logic [1:0]      ctr_q   [BHT_DEPTH];
    logic [1:0]      ctr_d   [BHT_DEPTH];
    logic [XLEN-1:0] tgt_q   [BHT_DEPTH];
    logic [XLEN-1:0] tgt_d   [BHT_DEPTH];

    logic            redirect_valid_q, redirect_valid_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic            res_taken_q, res_taken_d;
    logic [CNT_W-1:0] br_count_q, br_count_d;
    logic [CNT_W-1:0] mispred_count_q, mispred_count_d;

    logic [IDX-1:0]  f_idx;
    logic [IDX-1:0]  ex_idx;
    logic            is_branch;
    logic            cond_true;
    logic            actual_taken;
    logic [XLEN-1:0] actual_next;
    logic            mispredict;
    logic            upd_en;

    // Fetch lookup reads only registered state, so a same-cycle update is not visible yet.
    assign f_idx         = f_pc[IDX+1:2];
    assign f_pred_taken  = valid_q[f_idx] & ctr_q[f_idx][1];
    assign f_pred_target = f_pred_taken ? tgt_q[f_idx] : f_pc + PC_STEP;

    assign ex_idx    = ex_pc[IDX+1:2];
    assign is_branch = (ex_format == FMT_B);

    always_comb begin
        cond_true = 1'b0;
        unique case (ex_funct3)
            3'b000:  cond_true = (ex_a == ex_b);
            3'b001:  cond_true = (ex_a != ex_b);
            3'b100:  cond_true = ($signed(ex_a) <  $signed(ex_b));
            3'b101:  cond_true = ($signed(ex_a) >= $signed(ex_b));
            3'b110:  cond_true = (ex_a <  ex_b);
            3'b111:  cond_true = (ex_a >= ex_b);
            default: cond_true = 1'b0;
        endcase
    end

    assign actual_taken = is_branch & cond_true;
    assign actual_next  = actual_taken ? ex_pc + ex_imm : ex_pc + PC_STEP;
    assign mispredict   = ex_valid & ((ex_pred_taken != actual_taken) ||
                                      (ex_pred_target != actual_next));
    assign upd_en       = ex_valid & is_branch;

    always_comb begin
        valid_d = valid_q;
        ctr_d   = ctr_q;
        tgt_d   = tgt_q;
        if (upd_en) begin
            if (actual_taken) begin
                valid_d[ex_idx] = 1'b1;
                tgt_d[ex_idx]   = actual_next;
                if (ctr_q[ex_idx] != 2'b11) begin
                    ctr_d[ex_idx] = ctr_q[ex_idx] + 2'd1;
                end
            end else if (ctr_q[ex_idx] != 2'b00) begin
                ctr_d[ex_idx] = ctr_q[ex_idx] - 2'd1;
            end
        end
    end

    // Resolution results persist until the next valid instruction; only the pulse drops.
    always_comb begin
        redirect_valid_d = mispredict;
        redirect_pc_d    = redirect_pc_q;
        res_taken_d      = res_taken_q;
        br_count_d       = br_count_q;
        mispred_count_d  = mispred_count_q;
        if (ex_valid) begin
            redirect_pc_d = actual_next;
            res_taken_d   = actual_taken;
        end
        if (upd_en && br_count_q != CNT_MAX) begin
            br_count_d = br_count_q + CNT_ONE;
        end
        if (mispredict && mispred_count_q != CNT_MAX) begin
            mispred_count_d = mispred_count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= 2'b01;
                tgt_q[i]   <= '0;
            end
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            res_taken_q      <= 1'b0;
            br_count_q       <= '0;
            mispred_count_q  <= '0;
        end else begin
            valid_q          <= valid_d;
            ctr_q            <= ctr_d;
            tgt_q            <= tgt_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            res_taken_q      <= res_taken_d;
            br_count_q       <= br_count_d;
            mispred_count_q  <= mispred_count_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign res_taken      = res_taken_q;
    assign br_count       = br_count_q;
    assign mispred_count  = mispred_count_q;

endmodule
